// File: rtl/fir_mac_controller.sv
// Control FSM for the FIR multiply-accumulate datapath: accepts a sample, walks
// LENGTH taps through the datapath counter, then hands the sum downstream.
module fir_mac_controller #(
   parameter int LENGTH = 100,
   parameter int CNT_W  = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic out_ready,
   output logic out_valid,
   input  logic dp_rollBack,
   output logic dp_rst,
   output logic dp_shift_enb,
   output logic dp_count_enb,
   output logic register_enb,
   output logic resetReg,
   output logic err
);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_MAC
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST_TAP = CNT_W'(LENGTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_tap_cnt;
   logic [CNT_W-1:0] w_tap_cnt_next;
   logic             r_err;
   logic             w_err_next;
   logic             w_last_tap;
   logic             w_mismatch;

   // The datapath's rollBack must agree with our own view of the final tap.
   assign w_last_tap = (r_tap_cnt == C_LAST_TAP);
   assign w_mismatch = (dp_rollBack != w_last_tap);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_INIT;
         r_tap_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_tap_cnt <= w_tap_cnt_next;
         r_err     <= w_err_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_tap_cnt_next = r_tap_cnt;
      w_err_next     = r_err;
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      dp_rst         = 1'b0;
      dp_shift_enb   = 1'b0;
      dp_count_enb   = 1'b0;
      register_enb   = 1'b0;
      resetReg       = 1'b0;

      case (r_state)
         S_INIT: begin
            dp_rst         = 1'b1;
            resetReg       = 1'b1;
            w_tap_cnt_next = '0;
            w_state_next   = S_IDLE;
         end

         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               dp_shift_enb   = 1'b1;
               resetReg       = 1'b1;
               w_tap_cnt_next = '0;
               w_state_next   = S_MAC;
            end
         end

         S_MAC: begin
            if (w_mismatch) begin
               // Drop the sample and resynchronise the datapath through INIT.
               w_err_next     = 1'b1;
               w_tap_cnt_next = '0;
               w_state_next   = S_INIT;
            end else if (!dp_rollBack) begin
               dp_count_enb   = 1'b1;
               register_enb   = 1'b1;
               w_tap_cnt_next = r_tap_cnt + 1'b1;
            end else begin
               out_valid = 1'b1;
               if (out_ready) begin
                  dp_count_enb   = 1'b1;
                  w_tap_cnt_next = '0;
                  w_state_next   = S_IDLE;
               end
            end
         end

         default: begin
            w_state_next = S_INIT;
         end
      endcase
   end

   assign err = r_err;

endmodule

// File: tb/tb_fir_mac_controller.sv
// Bench for fir_mac_controller: a behavioural datapath responder plus a
// convolution reference over the accepted-sample history.
module tb_fir_mac_controller;

   localparam int LENGTH = 100;
   localparam int CNT_W  = 7;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic in_ready;
   logic out_ready;
   logic out_valid;
   logic dp_rollBack;
   logic dp_rst;
   logic dp_shift_enb;
   logic dp_count_enb;
   logic register_enb;
   logic resetReg;
   logic err;

   always #5 clk = ~clk;

   fir_mac_controller #(.LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .dp_rollBack  (dp_rollBack),
      .dp_rst       (dp_rst),
      .dp_shift_enb (dp_shift_enb),
      .dp_count_enb (dp_count_enb),
      .register_enb (register_enb),
      .resetReg     (resetReg),
      .err          (err)
   );

   // Datapath responder: register file, tap pointer and accumulator.
   int     coef [LENGTH];
   int     xr   [LENGTH];
   int     din;
   int     dp_ptr = 0;
   int     cyc = 0;
   longint acc = 0;
   longint prod;
   longint dp_out;
   logic   force_rb;

   assign dp_rollBack = force_rb | (dp_ptr == LENGTH - 1);

   always_comb begin
      prod   = longint'(xr[dp_ptr]) * coef[dp_ptr];
      dp_out = acc + prod;
   end

   always @(posedge clk) begin
      if (dp_rst) begin
         for (int k = 0; k < LENGTH; k++) xr[k] <= 0;
         dp_ptr <= 0;
      end else begin
         if (dp_shift_enb) begin
            for (int k = LENGTH - 1; k > 0; k--) xr[k] <= xr[k-1];
            xr[0] <= din;
         end
         if (dp_count_enb) dp_ptr <= (dp_ptr == LENGTH - 1) ? 0 : dp_ptr + 1;
      end
      if (resetReg) acc <= 0;
      else if (register_enb) acc <= acc + prod;
      cyc <= cyc + 1;
   end

   // Reference: newest-first history of accepted samples since the last clear.
   int hist[$];
   bit exp_err;
   bit have_prev;
   int last_hs;
   int last_stall;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic longint ref_sum();
      longint s = 0;
      for (int k = 0; k < LENGTH && k < hist.size(); k++) s += longint'(coef[k]) * hist[k];
      return s;
   endfunction

   task automatic check(input string name, input longint got, input longint expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_txn(input int sample, input int stall, input int bad_tap,
                         input int rst_tap, input bit exp_valid, input bit chk_gap);
      int     t_hs;
      int     wait_n;
      int     bad_mac;
      int     bad_hold;
      bit     got_valid;
      bit     done;
      longint held;
      din = sample;
      in_valid = 1'b1;
      out_ready = 1'b0;
      #1;
      wait_n = 0;
      while (!in_ready && wait_n < LENGTH + 10) begin
         tick(); #1;
         wait_n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      t_hs = cyc;
      check("accept_strobes", {dp_shift_enb, resetReg, dp_count_enb, out_valid}, 4'b1100);
      if (chk_gap && have_prev) check("handshake_gap", t_hs - last_hs, LENGTH + 1 + last_stall);
      hist.push_front(sample);
      if (hist.size() > LENGTH) void'(hist.pop_back());
      $display("txn sample=%0d stall=%0d bad_tap=%0d rst_tap=%0d accepted at cycle %0d",
               sample, stall, bad_tap, rst_tap, t_hs);

      tick();
      in_valid = 1'b0;
      #1;
      got_valid = 1'b0;
      done = 1'b0;
      bad_mac = 0;
      for (int j = 0; j < LENGTH + 10 && !done; j++) begin
         if (j == bad_tap) begin
            force_rb = 1'b1; #1;
            check("mismatch_out_valid", out_valid, 0);
            tick();
            force_rb = 1'b0; #1;
            check("mismatch_init", {dp_rst, resetReg, in_ready, out_valid}, 4'b1100);
            exp_err = 1'b1;
            hist.delete();
            check("err_sticky", err, exp_err);
            tick(); #1;
            check("mismatch_idle", {in_ready, dp_rst}, 2'b10);
            done = 1'b1;
         end else if (j == rst_tap) begin
            rst = 1'b1; #1;
            check("rst_async_outputs",
                  {dp_rst, resetReg, in_ready, out_valid, dp_count_enb, register_enb, dp_shift_enb, err},
                  8'b11000000);
            tick(); tick();
            rst = 1'b0; #1;
            exp_err = 1'b0;
            hist.delete();
            check("rst_release_init", {dp_rst, in_ready}, 2'b10);
            tick(); #1;
            check("rst_idle", {in_ready, dp_rst}, 2'b10);
            done = 1'b1;
         end else if (out_valid) begin
            got_valid = 1'b1;
            done = 1'b1;
            check("latency", j + 1, LENGTH);
            check("dp_out_sum", dp_out, ref_sum());
            check("err_level", err, exp_err);
            held = dp_out;
            bad_hold = 0;
            for (int s = 0; s < stall; s++) begin
               if (!out_valid || dp_count_enb || register_enb || in_ready || dp_out != held) bad_hold++;
               tick(); #1;
            end
            check("hold_violations", bad_hold, 0);
            check("hold_dp_out", dp_out, held);
            out_ready = 1'b1; #1;
            check("release_strobes", {out_valid, dp_count_enb, register_enb, in_ready}, 4'b1100);
            tick();
            out_ready = 1'b0; #1;
            check("back_to_idle", {in_ready, dp_ptr == 0}, 2'b11);
            $display("txn sample=%0d result=%0d expected=%0d", sample, held, ref_sum());
         end else begin
            if (!(dp_count_enb && register_enb) || in_ready || out_valid || dp_shift_enb) bad_mac++;
            tick(); #1;
         end
      end
      check("mac_enable_violations", bad_mac, 0);
      check("result_produced", got_valid, exp_valid);
      if (!done) check("out_valid_timeout", 0, 1);
      have_prev  = got_valid;
      last_hs    = t_hs;
      last_stall = stall;
   endtask

   typedef struct {
      int sample;
      int stall;
      int bad_tap;
      int rst_tap;
      bit exp_valid;
      bit chk_gap;
   } vec_t;

   vec_t vt[10];

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      din = 0;
      force_rb = 1'b0;
      exp_err = 1'b0;
      have_prev = 1'b0;
      last_hs = 0;
      last_stall = 0;
      for (int k = 0; k < LENGTH; k++) coef[k] = 1;

      vt[0] = '{5,  0,  -1, -1, 1'b1, 1'b0};
      vt[1] = '{1,  0,  -1, -1, 1'b1, 1'b1};
      vt[2] = '{2,  0,  -1, -1, 1'b1, 1'b1};
      vt[3] = '{3,  0,  -1, -1, 1'b1, 1'b1};
      vt[4] = '{7,  10, -1, -1, 1'b1, 1'b1};
      vt[5] = '{9,  0,  -1, -1, 1'b1, 1'b1};
      vt[6] = '{21, 0,  40, -1, 1'b0, 1'b1};
      vt[7] = '{4,  0,  -1, -1, 1'b1, 1'b0};
      vt[8] = '{33, 0,  -1, 50, 1'b0, 1'b1};
      vt[9] = '{6,  2,  -1, -1, 1'b1, 1'b0};

      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_outputs", {dp_rst, resetReg, in_ready, out_valid, err}, 5'b11000);
         tick(); #1;
      end
      rst = 1'b0; #1;
      check("init_after_rst", {dp_rst, resetReg, in_ready}, 3'b110);
      tick(); #1;
      check("idle_after_init", {dp_rst, in_ready, err}, 3'b010);

      for (int i = 0; i < 10; i++) begin
         do_txn(vt[i].sample, vt[i].stall, vt[i].bad_tap, vt[i].rst_tap,
                vt[i].exp_valid, vt[i].chk_gap);
         if (i == 0) begin
            for (int k = 0; k < LENGTH; k++) coef[k] = int'($urandom_range(0, 15));
         end
      end

      for (int i = 0; i < 12; i++) begin
         do_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), -1, -1, 1'b1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fir_mac_controller.md
Name: fir_mac_controller

Overview:
- Control FSM that drives the FIR multiply-accumulate datapath, which is the responder to this block.
- Takes input samples over a valid/ready handshake and shifts each one into the datapath register file.
- Sequences LENGTH tap multiply-accumulates through the datapath coefficient counter, then presents the filter result with a valid/ready output handshake.
- Checks the datapath rollBack against its own tap count and flags protocol errors.

Parameters:
- LENGTH, 100, number of FIR taps; must match the datapath LENGTH. Legal range is 1 or more.
- CNT_W, 7, width of the internal tap counter; must satisfy 2^CNT_W > LENGTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has a sample on the datapath data input.
- in_ready  out  1  controller accepts a sample this cycle.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  datapath dp_out holds the full filter sum.
- dp_rollBack  in  1  datapath counter is at LENGTH-1; combinational from the counter.
- dp_rst  out  1  synchronous clear of the datapath register file and counter.
- dp_shift_enb  out  1  shift the input sample into the register file.
- dp_count_enb  out  1  advance the coefficient/tap pointer.
- register_enb  out  1  load the accumulator register.
- resetReg  out  1  clear the accumulator register.
- err  out  1  sticky rollBack mismatch flag; cleared only by rst.

Behaviour:
- States: INIT, IDLE, MAC. Encoding is free.
- rst asserted, at any time including mid-MAC:
  - state goes to INIT and the tap counter to 0.
  - err goes to 0.
  - All outputs are 0 except dp_rst=1 and resetReg=1.
- INIT: one cycle.
  - dp_rst=1, resetReg=1, in_ready=0.
  - Next state is IDLE.
- IDLE:
  - in_ready=1. The datapath pointer is 0 here.
  - On in_valid=1 (Mealy, same cycle): dp_shift_enb=1 and resetReg=1.
  - Next state is MAC; the tap counter loads 0.
  - With in_valid=0: all enables are 0 and the state holds.
- MAC, while dp_rollBack=0:
  - dp_count_enb=1, register_enb=1, tap counter +1.
  - out_valid=0 and in_ready=0.
- MAC, while dp_rollBack=1 (final tap):
  - out_valid=1 and register_enb=0.
  - dp_out is combinational (accumulator + product of the final tap), so it equals the full sum.
  - out_ready=0: hold. out_valid stays 1 and all enables stay 0, so dp_out is stable.
  - out_ready=1: dp_count_enb=1 so the pointer wraps to 0; next state is IDLE.
- Latency:
  - Input handshake in cycle T gives out_valid from cycle T+LENGTH.
  - Throughput is one sample per LENGTH+1 cycles when out_ready is held at 1.
- LENGTH=1: dp_rollBack is already 1 on entry to MAC, so out_valid is asserted in cycle T+1.
- Error check:
  - Trigger: in MAC, dp_rollBack=1 while tap counter != LENGTH-1, or tap counter reaches LENGTH-1 while dp_rollBack=0.
  - Response: err<=1, out_valid is suppressed that cycle, next state is INIT to resynchronise the datapath.
  - No output is produced for that sample.
- Outputs are 0 in any state or case not listed above.
- in_ready never asserts outside IDLE, so there is no simultaneous input and output handshake.
- Register the state and tap counter. Enables and valid/ready are decoded combinationally from state and inputs.

Test Plan:
- Reset and INIT:
  - Stimulus: assert rst for 3 cycles, then release.
  - Required: dp_rst=1 during rst and for 1 cycle after; in_ready=1 on the 2nd cycle after release; err=0.
- Single sample, LENGTH=100, out_ready=1:
  - Stimulus: in_valid pulse at cycle T.
  - Required: dp_shift_enb and resetReg high at T only; dp_count_enb high for T+1..T+99; out_valid high only at T+100; in_ready high again at T+101.
  - With a datapath model (taps all 1, sample 5): dp_out=5 at T+100.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles once out_valid rises.
  - Required: out_valid stays 1 and dp_count_enb, register_enb, in_ready stay 0; one cycle after out_ready=1 the state is IDLE and the pointer is 0.
- Back-to-back samples:
  - Stimulus: in_valid held 1, samples 1, 2, 3, out_ready=1.
  - Required: in_ready handshakes 101 cycles apart; 3 out_valid pulses with sums matching a golden convolution.
- Mismatch:
  - Stimulus: force dp_rollBack=1 at MAC tap 40.
  - Required: err=1 sticky; out_valid stays 0; INIT (dp_rst=1) next cycle; the next sample then completes normally.
- Reset mid-MAC:
  - Stimulus: assert rst at tap 50.
  - Required: outputs go to reset values immediately (asynchronous); no out_valid is produced; after release the next sample yields a correct sum.
